// File: rtl/ucisc_debug_pkg.sv
// Shared opcodes and run-control states for the uCISC debug controller.
package ucisc_debug_pkg;

   localparam logic [2:0] OP_HALT        = 3'd0;
   localparam logic [2:0] OP_RESUME      = 3'd1;
   localparam logic [2:0] OP_STEP        = 3'd2;
   localparam logic [2:0] OP_SET_BP      = 3'd3;
   localparam logic [2:0] OP_CLR_BP      = 3'd4;
   localparam logic [2:0] OP_PEEK        = 3'd5;
   localparam logic [2:0] OP_READ_PC     = 3'd6;
   localparam logic [2:0] OP_READ_ICOUNT = 3'd7;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1,
      ST_STEP = 2'd2
   } dbg_state_t;

endpackage

// File: rtl/ucisc_debug_ctrl_bp_match.sv
// Breakpoint register bank: per-slot address and enable, with a combinational
// "current pc hits an enabled slot" output.
module ucisc_bp_match
   import ucisc_debug_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int BREAKPOINTS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_wr_en,
   input  logic             i_wr_set,
   input  logic [7:0]       i_wr_sel,
   input  logic [WIDTH-1:0] i_wr_addr,
   input  logic [WIDTH-1:0] i_pc,
   output logic             o_match
);

   logic [WIDTH-1:0]       r_addr [BREAKPOINTS];
   logic [BREAKPOINTS-1:0] r_en;

   // A clear only drops the enable; the stale address is harmless.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_en <= '0;
         for (int i = 0; i < BREAKPOINTS; i++) begin
            r_addr[i] <= '0;
         end
      end else if (i_wr_en) begin
         for (int i = 0; i < BREAKPOINTS; i++) begin
            if (i_wr_sel == 8'(i)) begin
               r_en[i] <= i_wr_set;
               if (i_wr_set) begin
                  r_addr[i] <= i_wr_addr;
               end
            end
         end
      end
   end

   always_comb begin
      o_match = 1'b0;
      for (int i = 0; i < BREAKPOINTS; i++) begin
         if (r_en[i] && (r_addr[i] == i_pc)) begin
            o_match = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ucisc_debug_ctrl.sv
// Run-control unit for the uCISC CPU: gates the per-step clock enable and
// serves halt/resume/step, breakpoints, peeks and an instruction counter.
module ucisc_debug_ctrl
   import ucisc_debug_pkg::*;
#(
   parameter int WIDTH        = 16,
   parameter int STEP_BITS    = 2,
   parameter int CHANNELS     = 4,
   parameter int BREAKPOINTS  = 2,
   parameter bit START_HALTED = 1'b0
) (
   input  logic                      clock_input,
   input  logic                      reset,
   input  logic [STEP_BITS-1:0]      step,
   input  logic [WIDTH-1:0]          pc,
   input  logic [CHANNELS*WIDTH-1:0] peek_data,
   output logic                      cpu_en,
   output logic                      halted,
   output logic [WIDTH-1:0]          icount,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [2:0]                cmd_op,
   input  logic [7:0]                cmd_sel,
   input  logic [WIDTH-1:0]          cmd_arg,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [WIDTH-1:0]          rsp_data,
   output logic [1:0]                o_dbg_state
);

   localparam dbg_state_t RESET_STATE = START_HALTED ? ST_HALT : ST_RUN;

   dbg_state_t       r_state;
   dbg_state_t       w_state_nxt;
   logic             r_skip;
   logic [WIDTH-1:0] r_icount;
   logic             r_rsp_valid;
   logic [WIDTH-1:0] r_rsp_data;

   logic             w_step_first;
   logic             w_step_last;
   logic             w_cmd_acc;
   logic             w_bp_any;
   logic             w_bp_hit;
   logic             w_cpu_en;
   logic             w_bp_sel_ok;
   logic             w_bp_wr;
   logic             w_skip_set;
   logic [WIDTH-1:0] w_peek;
   logic [WIDTH-1:0] w_halt_flag;
   logic [WIDTH-1:0] w_rsp_nxt;

   // Handshakes: a command transfers on an edge where cmd_valid && cmd_ready;
   // a response transfers where rsp_valid && rsp_ready, and rsp_valid/rsp_data
   // hold steady until then. Only one response is ever outstanding.
   assign w_cmd_acc    = cmd_valid && !r_rsp_valid;
   assign w_step_first = (step == '0);
   assign w_step_last  = (step == '1);
   assign w_bp_sel_ok  = (cmd_sel < 8'(BREAKPOINTS));
   assign w_bp_wr      = w_cmd_acc && w_bp_sel_ok
                         && ((cmd_op == OP_SET_BP) || (cmd_op == OP_CLR_BP));
   assign w_skip_set   = w_cmd_acc && (r_state == ST_HALT)
                         && ((cmd_op == OP_RESUME) || (cmd_op == OP_STEP));

   // The match stays combinational so the trapped instruction never starts.
   assign w_bp_hit = (r_state == ST_RUN) && w_step_first && !r_skip && w_bp_any;

   ucisc_bp_match #(
      .WIDTH       (WIDTH),
      .BREAKPOINTS (BREAKPOINTS)
   ) u_bp_match (
      .clk       (clock_input),
      .reset     (reset),
      .i_wr_en   (w_bp_wr),
      .i_wr_set  (cmd_op == OP_SET_BP),
      .i_wr_sel  (cmd_sel),
      .i_wr_addr (cmd_arg),
      .i_pc      (pc),
      .o_match   (w_bp_any)
   );

   always_comb begin
      w_cpu_en = 1'b0;
      case (r_state)
         ST_RUN:  w_cpu_en = !w_bp_hit;
         ST_STEP: w_cpu_en = 1'b1;
         default: w_cpu_en = 1'b0;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:  if (w_bp_hit) w_state_nxt = ST_HALT;
         ST_STEP: if (w_step_last) w_state_nxt = ST_HALT;
         default: w_state_nxt = r_state;
      endcase
      if (w_cmd_acc) begin
         case (cmd_op)
            OP_HALT:   w_state_nxt = ST_HALT;
            OP_RESUME: if (r_state == ST_HALT) w_state_nxt = ST_RUN;
            OP_STEP:   if (r_state == ST_HALT) w_state_nxt = ST_STEP;
            default:   ;
         endcase
      end
   end

   always_comb begin
      w_peek = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (cmd_sel == 8'(k)) begin
            w_peek = peek_data[k*WIDTH +: WIDTH];
         end
      end
   end

   assign w_halt_flag = {{(WIDTH-1){1'b0}}, (w_state_nxt == ST_HALT)};

   always_comb begin
      w_rsp_nxt = '0;
      case (cmd_op)
         OP_HALT, OP_RESUME, OP_STEP: w_rsp_nxt = w_halt_flag;
         OP_SET_BP, OP_CLR_BP:        if (w_bp_sel_ok) w_rsp_nxt = w_halt_flag;
         OP_PEEK:                     w_rsp_nxt = w_peek;
         OP_READ_PC:                  w_rsp_nxt = pc;
         OP_READ_ICOUNT:              w_rsp_nxt = r_icount;
         default:                     w_rsp_nxt = '0;
      endcase
   end

   always_ff @(posedge clock_input) begin
      if (reset) begin
         r_state     <= RESET_STATE;
         r_skip      <= 1'b0;
         r_icount    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         // Skip lets a resumed breakpoint instruction start, then re-arms.
         if (w_skip_set) begin
            r_skip <= 1'b1;
         end else if (w_cpu_en && w_step_first) begin
            r_skip <= 1'b0;
         end
         if (w_cpu_en && w_step_last) begin
            r_icount <= r_icount + 1'b1;
         end
         if (w_cmd_acc) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rsp_nxt;
         end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign cpu_en      = w_cpu_en;
   assign halted      = (r_state == ST_HALT);
   assign icount      = r_icount;
   assign cmd_ready   = !r_rsp_valid;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_data    = r_rsp_data;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ucisc_debug_ctrl.sv
// Bench for ucisc_debug_ctrl: a tiny CPU step/pc model driven by cpu_en plus a
// response scoreboard fed when each command is driven.
module tb_ucisc_debug_ctrl;
   import ucisc_debug_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  step;
   logic [15:0] pc;
   logic [63:0] peek_data;
   logic        cpu_en;
   logic        halted;
   logic [15:0] icount;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [7:0]  cmd_sel;
   logic [15:0] cmd_arg;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic [1:0]  dbg_state;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   logic        acc_seen = 1'b0;
   logic        last_en = 1'b0;
   logic [15:0] ch3_val;
   logic [15:0] exp_q[$];

   ucisc_debug_ctrl dut (
      .clock_input (clk),
      .reset       (reset),
      .step        (step),
      .pc          (pc),
      .peek_data   (peek_data),
      .cpu_en      (cpu_en),
      .halted      (halted),
      .icount      (icount),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_sel     (cmd_sel),
      .cmd_arg     (cmd_arg),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- driver: one clock with CPU model and scoreboard ----------------
   task automatic tick();
      logic en_pre, hs, acc, rst_pre;
      logic [15:0] data_pre, exp_v;
      en_pre   = cpu_en;
      hs       = rsp_valid && rsp_ready;
      acc      = cmd_valid && cmd_ready;
      data_pre = rsp_data;
      rst_pre  = reset;
      @(posedge clk);
      #1;
      cyc++;
      last_en = en_pre && !rst_pre;
      if (hs && !rst_pre) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++; $display("FAIL rsp_unexpected got=%h exp=none", data_pre);
         end else begin
            exp_v = exp_q.pop_front();
            if (data_pre !== exp_v) begin
               errors++; $display("FAIL rsp_data got=%h exp=%h", data_pre, exp_v);
            end
         end
      end
      if (acc && !rst_pre) begin
         cmd_valid = 1'b0;
         acc_seen  = 1'b1;
         acc_cyc   = cyc;
      end
      if (last_en) begin
         if (step == 2'd3) pc = pc + 16'd1;
         step = step + 2'd1;
      end
      #1;
   endtask

   task automatic send_cmd(input logic [2:0] op, input logic [7:0] sel,
                           input logic [15:0] arg, input logic [15:0] exp_v);
      int n;
      cmd_op = op; cmd_sel = sel; cmd_arg = arg; cmd_valid = 1'b1;
      exp_q.push_back(exp_v);
      acc_seen = 1'b0;
      n = 0;
      while (!acc_seen && n < 20) begin tick(); n++; end
      if (!acc_seen) begin
         checks++; errors++;
         $display("FAIL cmd_accept op=%0d got=not_accepted exp=accepted", op);
         cmd_valid = 1'b0;
         void'(exp_q.pop_back());
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin tick(); n++; end
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL rsp_timeout got=pending%0d exp=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL reset_cpu_en got=%b exp=1", cpu_en); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
      checks++; if (icount !== 16'd0) begin errors++; $display("FAIL reset_icount got=%h exp=0000", icount); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (rsp_data !== 16'd0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0000", rsp_data); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
      checks++; if (dbg_state !== ST_RUN) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_RUN); end
   endtask

   task automatic test_run();
      repeat (12) tick();
      checks++; if (icount !== 16'd3) begin errors++; $display("FAIL run_icount got=%h exp=0003", icount); end
      checks++; if (pc !== 16'd3) begin errors++; $display("FAIL run_pc got=%h exp=0003", pc); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL run_halted got=%b exp=0", halted); end
      checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL run_cpu_en got=%b exp=1", cpu_en); end
   endtask

   task automatic test_breakpoint();
      int n;
      send_cmd(OP_SET_BP, 8'd1, 16'h0004, 16'h0000);
      n = 0;
      while (!(pc == 16'd4 && step == 2'd0) && n < 40) begin tick(); n++; end
      if (!(pc == 16'd4 && step == 2'd0)) begin
         checks++; errors++; $display("FAIL bp_reach got=pc%h exp=pc0004", pc);
      end
      checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL bp_cpu_en_same_cycle got=%b exp=0", cpu_en); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL bp_halted_same_cycle got=%b exp=0", halted); end
      tick();
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL bp_halted got=%b exp=1", halted); end
      checks++; if (dbg_state !== ST_HALT) begin errors++; $display("FAIL bp_state got=%0d exp=%0d", dbg_state, ST_HALT); end
      checks++; if (pc !== 16'd4 || step !== 2'd0) begin errors++; $display("FAIL bp_hold got=%h/%0d exp=0004/0", pc, step); end
      checks++; if (icount !== 16'd4) begin errors++; $display("FAIL bp_icount got=%h exp=0004", icount); end
   endtask

   task automatic test_resume();
      send_cmd(OP_RESUME, 8'd0, 16'h0000, 16'h0000);
      repeat (4) tick();
      checks++; if (pc !== 16'd5 || step !== 2'd0) begin errors++; $display("FAIL resume_pos got=%h/%0d exp=0005/0", pc, step); end
      checks++; if (icount !== 16'd5) begin errors++; $display("FAIL resume_icount got=%h exp=0005", icount); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL resume_halted got=%b exp=0", halted); end
   endtask

   task automatic test_step();
      int n, en_cnt;
      send_cmd(OP_SET_BP, 8'd0, 16'h0007, 16'h0000);
      n = 0;
      while (!halted && n < 40) begin tick(); n++; end
      checks++; if (pc !== 16'd7 || step !== 2'd0) begin errors++; $display("FAIL bp2_pos got=%h/%0d exp=0007/0", pc, step); end
      checks++; if (icount !== 16'd7) begin errors++; $display("FAIL bp2_icount got=%h exp=0007", icount); end
      send_cmd(OP_CLR_BP, 8'd0, 16'h0000, 16'h0001);
      drain();
      send_cmd(OP_STEP, 8'd0, 16'h0000, 16'h0000);
      en_cnt = 0; n = 0;
      while (!halted && n < 20) begin tick(); if (last_en) en_cnt++; n++; end
      checks++; if (en_cnt !== 4) begin errors++; $display("FAIL step_en_cycles got=%0d exp=4", en_cnt); end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL step_halted got=%b exp=1", halted); end
      checks++; if (pc !== 16'd8 || step !== 2'd0) begin errors++; $display("FAIL step_pos got=%h/%0d exp=0008/0", pc, step); end
      checks++; if (icount !== 16'd8) begin errors++; $display("FAIL step_icount got=%h exp=0008", icount); end
      drain();
      send_cmd(OP_READ_ICOUNT, 8'd0, 16'h0000, 16'h0008);
      drain();
   endtask

   task automatic test_peek();
      rsp_ready = 1'b0;
      send_cmd(OP_PEEK, 8'd1, 16'h0000, 16'h07FF);
      for (int i = 0; i < 3; i++) begin
         checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL peek_hold_valid c%0d got=%b exp=1", i, rsp_valid); end
         checks++; if (rsp_data !== 16'h07FF) begin errors++; $display("FAIL peek_hold_data c%0d got=%h exp=07ff", i, rsp_data); end
         checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL peek_cmd_ready c%0d got=%b exp=0", i, cmd_ready); end
         tick();
      end
      rsp_ready = 1'b1;
      drain();
      send_cmd(OP_PEEK, 8'd9, 16'h0000, 16'h0000);
      drain();
      send_cmd(OP_PEEK, 8'd3, 16'h0000, ch3_val);
      drain();
      send_cmd(OP_READ_PC, 8'd0, 16'h0000, 16'h0008);
      drain();
      send_cmd(OP_SET_BP, 8'd5, 16'h0008, 16'h0000);
      drain();
      send_cmd(OP_HALT, 8'd0, 16'h0000, 16'h0001);
      drain();
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL peek_still_halted got=%b exp=1", halted); end
   endtask

   task automatic test_back_to_back();
      int a;
      send_cmd(OP_READ_PC, 8'd0, 16'h0000, 16'h0008);
      a = acc_cyc;
      send_cmd(OP_READ_ICOUNT, 8'd0, 16'h0000, 16'h0008);
      checks++; if (acc_cyc - a !== 2) begin errors++; $display("FAIL b2b_gap1 got=%0d exp=2", acc_cyc - a); end
      a = acc_cyc;
      send_cmd(OP_PEEK, 8'd1, 16'h0000, 16'h07FF);
      checks++; if (acc_cyc - a !== 2) begin errors++; $display("FAIL b2b_gap2 got=%0d exp=2", acc_cyc - a); end
      drain();
   endtask

   task automatic test_halt_reset();
      int n;
      send_cmd(OP_RESUME, 8'd0, 16'h0000, 16'h0000);
      drain();
      n = 0;
      while (step != 2'd2 && n < 10) begin tick(); n++; end
      rsp_ready = 1'b0;
      send_cmd(OP_HALT, 8'd0, 16'h0000, 16'h0001);
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL midhalt_halted got=%b exp=1", halted); end
      checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL midhalt_cpu_en got=%b exp=0", cpu_en); end
      tick();
      checks++; if (step !== 2'd3) begin errors++; $display("FAIL midhalt_step got=%0d exp=3", step); end
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0001) begin errors++; $display("FAIL midhalt_rsp got=%b/%h exp=1/0001", rsp_valid, rsp_data); end
      reset = 1'b1; step = 2'd0; pc = 16'd0;
      tick();
      exp_q.delete();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst2_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (rsp_data !== 16'd0) begin errors++; $display("FAIL rst2_rsp_data got=%h exp=0000", rsp_data); end
      checks++; if (halted !== 1'b0 || cpu_en !== 1'b1) begin errors++; $display("FAIL rst2_run got=%b/%b exp=0/1", halted, cpu_en); end
      checks++; if (icount !== 16'd0) begin errors++; $display("FAIL rst2_icount got=%h exp=0000", icount); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst2_cmd_ready got=%b exp=1", cmd_ready); end
      reset = 1'b0; rsp_ready = 1'b1;
      repeat (24) tick();
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst2_bp_cleared got=%b exp=0", halted); end
      checks++; if (pc !== 16'd6 || icount !== 16'd6) begin errors++; $display("FAIL rst2_progress got=%h/%h exp=0006/0006", pc, icount); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset = 1'b1; step = 2'd0; pc = 16'd0;
      cmd_valid = 1'b0; cmd_op = 3'd0; cmd_sel = 8'd0; cmd_arg = 16'd0; rsp_ready = 1'b1;
      ch3_val   = 16'($urandom_range(0, 65535));
      peek_data = {ch3_val, 16'($urandom_range(0, 65535)), 16'h07FF, 16'($urandom_range(0, 65535))};
      test_reset();
      test_run();
      test_breakpoint();
      test_resume();
      test_step();
      test_peek();
      test_back_to_back();
      test_halt_reset();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
